// File: rtl/a51_pkg.sv
// ---------------------------------------------------------------------------
// a51_pkg
// Definitions shared by the A5/1 datapath stages.
//   state_e  : LCD streamer sequencer states (IDLE, CLEAR, SEND, DONE)
//   ASCII_0  : ASCII code of the character '0'
//   ASCII_A  : ASCII code of the character 'A' (hex digits use uppercase)
// ---------------------------------------------------------------------------
package a51_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_A = 8'h41;

endpackage

// File: rtl/nibble_to_ascii.sv
// ---------------------------------------------------------------------------
// nibble_to_ascii
// Converts one hex digit to its uppercase ASCII character. Purely
// combinational. The key/data entry echo path uses the same converter.
//   nib_i   [3:0] : hex digit 0..F
//   ascii_o [7:0] : '0'..'9' (8'h30-8'h39) or 'A'..'F' (8'h41-8'h46)
// ---------------------------------------------------------------------------
module nibble_to_ascii
    import a51_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        ascii_o = ASCII_0 + {4'h0, nib_i};
        if (nib_i > 4'd9) begin
            ascii_o = ASCII_A + ({4'h0, nib_i} - 8'd10);
        end
    end

endmodule

// File: rtl/ciphertext_lcd_streamer.sv
// ---------------------------------------------------------------------------
// ciphertext_lcd_streamer
// Captures the XORed ciphertext/plaintext word and streams it to the
// character LCD as DATA_WIDTH/4 ASCII hex characters, most-significant
// nibble first, over a valid/ready handshake. Each message is preceded by a
// one-cycle LCD clear pulse, and completion is flagged with done_o.
//
// Ports
//   clk_i         : system clock, rising edge
//   reset_i       : synchronous active-low reset
//   start_i       : pulse, capture data_in_i and begin a message (IDLE/DONE)
//   data_in_i     : word to display, sampled only on an accepted start
//   lcd_ready_i   : LCD accepts a character this cycle
//   lcd_data_o    : ASCII character, 8'h00 whenever lcd_enable_o is low
//   lcd_enable_o  : lcd_data_o valid; transfer on lcd_enable_o & lcd_ready_i
//   lcd_reset_o   : one-cycle LCD clear pulse
//   busy_o        : message in progress (CLEAR or SEND)
//   done_o        : all characters transferred; held until restart/reset
//   char_index_o  : index of the character currently offered
// ---------------------------------------------------------------------------
module ciphertext_lcd_streamer
    import a51_pkg::*;
#(
    parameter  int DATA_WIDTH = 128,
    localparam int NIBBLES    = DATA_WIDTH / 4,
    localparam int IDX_W      = $clog2(NIBBLES)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  lcd_ready_i,
    output logic [7:0]            lcd_data_o,
    output logic                  lcd_enable_o,
    output logic                  lcd_reset_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [IDX_W-1:0]      char_index_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  lcd_enable_q;
    logic                  lcd_reset_q;
    logic                  busy_q;
    logic                  done_q;
    logic [7:0]            ascii;

    // Single sequencer; every output flag is a register so lcd_ready_i only
    // reaches the outputs through the state/index/shift registers.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            idx_q        <= '0;
            lcd_enable_q <= 1'b0;
            lcd_reset_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                // DONE accepts a start exactly like IDLE; done drops on capture.
                IDLE, DONE: begin
                    if (start_i) begin
                        shift_q     <= data_in_i;
                        idx_q       <= '0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        lcd_reset_q <= 1'b1;
                        state_q     <= CLEAR;
                    end
                end
                CLEAR: begin
                    lcd_reset_q  <= 1'b0;
                    lcd_enable_q <= 1'b1;
                    state_q      <= SEND;
                end
                SEND: begin
                    if (lcd_ready_i) begin
                        shift_q <= {shift_q[DATA_WIDTH-5:0], 4'h0};
                        if (idx_q == LAST_IDX) begin
                            // Index parks on the last character through DONE.
                            lcd_enable_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    nibble_to_ascii u_n2a (
        .nib_i   (shift_q[DATA_WIDTH-1 -: 4]),
        .ascii_o (ascii)
    );

    assign lcd_data_o   = lcd_enable_q ? ascii : 8'h00;
    assign lcd_enable_o = lcd_enable_q;
    assign lcd_reset_o  = lcd_reset_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign char_index_o = idx_q;

endmodule

// File: tb/tb_ciphertext_lcd_streamer.sv
module tb_ciphertext_lcd_streamer;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         start_i;
    logic [127:0] data_in_i;
    logic         lcd_ready_i;
    logic [7:0]   lcd_data_o;
    logic         lcd_enable_o;
    logic         lcd_reset_o;
    logic         busy_o;
    logic         done_o;
    logic [4:0]   char_index_o;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [127:0] WORD_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] ONES   = {128{1'b1}};
    localparam string STR_A = "0123456789ABCDEFFEDCBA9876543210";
    localparam string STR_F = "FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF";

    always #5 clk_i = ~clk_i;

    ciphertext_lcd_streamer dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .data_in_i    (data_in_i),
        .lcd_ready_i  (lcd_ready_i),
        .lcd_data_o   (lcd_data_o),
        .lcd_enable_o (lcd_enable_o),
        .lcd_reset_o  (lcd_reset_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .char_index_o (char_index_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // {lcd_reset, busy, done, lcd_enable}
    function automatic logic [31:0] flags();
        return {28'h0, lcd_reset_o, busy_o, done_o, lcd_enable_o};
    endfunction

    // Pulse start and check the CLEAR cycle that follows.
    task automatic kick(input logic [127:0] d);
        data_in_i = d;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        data_in_i = '0;
        chk("clear_flags", flags(), 32'b1100);
        chk("clear_data", {24'h0, lcd_data_o}, 32'h0);
        tick();
    endtask

    // Stream one message from the first SEND cycle. stall_mode 1 drives
    // lcd_ready 1,0,0,1,0,0... ; busy_start_at injects an ignored start;
    // abort_at pulls reset at that character index and stops.
    task automatic stream(input string exp, input int stall_mode,
                          input int busy_start_at, input int abort_at);
        int k = 0;
        int cyc = 0;
        int stalls = 0;
        logic rdy;
        while (k < 32 && cyc < 300) begin
            rdy = (stall_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            lcd_ready_i = rdy;
            chk("send_flags", flags(), 32'b0101);
            chk("send_data", {24'h0, lcd_data_o}, {24'h0, exp[k]});
            chk("send_idx", {27'h0, char_index_o}, k);
            if (k == abort_at) begin
                reset_i = 1'b0;
                tick();
                reset_i = 1'b1;
                chk("abort_flags", flags(), 32'b0000);
                chk("abort_idx", {27'h0, char_index_o}, 32'h0);
                chk("abort_data", {24'h0, lcd_data_o}, 32'h0);
                tick();
                chk("abort_stay", flags(), 32'b0000);
                lcd_ready_i = 1'b1;
                return;
            end
            if (k == busy_start_at && rdy) begin
                start_i   = 1'b1;
                data_in_i = ONES;
            end
            tick();
            start_i   = 1'b0;
            data_in_i = '0;
            if (rdy) k++;
            else     stalls++;
            cyc++;
        end
        lcd_ready_i = 1'b1;
        chk("xfer_count", k, 32);
        chk("latency", cyc, 32 + stalls);
        if (stall_mode != 0) chk("stall_count", stalls, 62);
        chk("done_flags", flags(), 32'b0010);
        chk("done_idx", {27'h0, char_index_o}, 32'd31);
        chk("done_data", {24'h0, lcd_data_o}, 32'h0);
        tick();
        chk("done_hold", flags(), 32'b0010);
    endtask

    initial begin
        reset_i     = 1'b0;
        start_i     = 1'b0;
        data_in_i   = '0;
        lcd_ready_i = 1'b1;

        // Reset, then idle with no start.
        tick();
        tick();
        chk("rst_flags", flags(), 32'b0000);
        chk("rst_idx", {27'h0, char_index_o}, 32'h0);
        reset_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_quiet", {19'h0, lcd_data_o, lcd_reset_o, busy_o, done_o, lcd_enable_o, 1'b0}
                              | {27'h0, char_index_o}, 32'h0);
        end

        // Full message, ready always high.
        kick(WORD_A);
        stream(STR_A, 0, -1, -1);

        // Backpressure 1,0,0 pattern: 31 gaps of two stalls = 62 extra cycles.
        kick(WORD_A);
        stream(STR_A, 1, -1, -1);

        // Start while busy at index 10 is ignored.
        kick(WORD_A);
        stream(STR_A, 0, 10, -1);

        // Restart from DONE with all ones.
        kick(ONES);
        stream(STR_F, 0, -1, -1);

        // Reset mid-message at index 20, then a clean full message.
        kick(WORD_A);
        stream(STR_A, 0, -1, 20);
        kick(WORD_A);
        stream(STR_A, 0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
